// File: rtl/snake_step_scanner_if.sv
// snake_step_scanner_if: step control, ROM address/data and display bus of the snake scanner
interface snake_step_scanner_if;
    logic       run;
    logic       dir;
    logic       step_once;
    logic [4:0] addr;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic [6:0] seg_c;
    logic [6:0] seg_d;
    logic [3:0] dp_in;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] com;
    logic       step_tick;
    logic       wrap;
    modport master (
        output run, dir, step_once, seg_a, seg_b, seg_c, seg_d, dp_in,
        input  addr, seg, dp, com, step_tick, wrap
    );
    modport slave (
        input  run, dir, step_once, seg_a, seg_b, seg_c, seg_d, dp_in,
        output addr, seg, dp, com, step_tick, wrap
    );
endinterface

// File: rtl/snake_step_scanner.sv
// snake_step_scanner: steps the shared snake ROM address and multiplexes the four digit patterns onto the display
module snake_step_scanner #(
    parameter int STEP_DIV  = 12_500_000,
    parameter int SCAN_DIV  = 50_000,
    parameter int LAST_ADDR = 19
) (
    input logic clk,
    input logic rst_n,
    snake_step_scanner_if.slave bus
);
    localparam int SW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [4:0]    ADDR_LAST = 5'(LAST_ADDR);

    logic [SW-1:0] pcnt;
    logic [CW-1:0] scnt;
    logic [1:0]    idx;
    logic          so_q;
    logic          so_h;
    logic          auto_ev;
    logic          man_ev;
    logic          ev;
    logic          at_end;
    logic [4:0]    nxt_addr;
    logic [6:0]    seg_sel;

    // manual steps count only while auto-advance is off
    assign auto_ev  = bus.run && pcnt == STEP_LAST;
    assign man_ev   = !bus.run && so_q && !so_h;
    assign ev       = auto_ev || man_ev;
    assign at_end   = bus.dir ? bus.addr == 5'd0 : bus.addr == ADDR_LAST;
    assign nxt_addr = bus.dir ? (at_end ? ADDR_LAST : bus.addr - 5'd1)
                              : (at_end ? 5'd0 : bus.addr + 5'd1);
    assign seg_sel  = idx == 2'd0 ? bus.seg_a :
                      idx == 2'd1 ? bus.seg_b :
                      idx == 2'd2 ? bus.seg_c : bus.seg_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt          <= '0;
            so_q          <= 1'b0;
            so_h          <= 1'b0;
            bus.addr      <= 5'd0;
            bus.step_tick <= 1'b0;
            bus.wrap      <= 1'b0;
        end else begin
            if (bus.run) pcnt <= auto_ev ? '0 : pcnt + 1'b1;
            so_q          <= bus.step_once;
            so_h          <= so_q;
            if (ev) bus.addr <= nxt_addr;
            bus.step_tick <= ev;
            bus.wrap      <= ev && at_end;
        end
    end

    // scan runs regardless of run; outputs lag the digit index by one register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt    <= '0;
            idx     <= 2'd0;
            bus.seg <= 7'h7F;
            bus.dp  <= 1'b1;
            bus.com <= 4'hF;
        end else begin
            scnt    <= scnt == SCAN_LAST ? '0 : scnt + 1'b1;
            if (scnt == SCAN_LAST) idx <= idx + 2'd1;
            bus.com <= ~(4'b0001 << idx);
            bus.seg <= seg_sel;
            bus.dp  <= bus.dp_in[idx];
        end
    end
endmodule

// File: tb/tb_snake_step_scanner.sv
// tb_snake_step_scanner: directed checks of stepping, manual steps, freeze/resume, scanning and async reset
module tb_snake_step_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [6:0] pat [4];

    snake_step_scanner_if bus();

    snake_step_scanner #(.STEP_DIV(4), .SCAN_DIV(3), .LAST_ADDR(19)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        pat[0] = 7'h7E; pat[1] = 7'h3F; pat[2] = 7'h77; pat[3] = 7'h3F;
        bus.run = 1'b0; bus.dir = 1'b0; bus.step_once = 1'b0;
        bus.seg_a = pat[0]; bus.seg_b = pat[1]; bus.seg_c = pat[2]; bus.seg_d = pat[3];
        bus.dp_in = 4'b1011;
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_com", 32'(bus.com), 32'hF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'd1);
        chk("rst_tick", 32'(bus.step_tick), 32'd0);
        chk("rst_wrap", 32'(bus.wrap), 32'd0);
        // forward auto stepping through a full wrap
        rst_n = 1'b1;
        bus.run = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            repeat (3) begin
                @(negedge clk);
                chk("fwd_idle_tick", 32'(bus.step_tick), 32'd0);
            end
            @(negedge clk);
            chk("fwd_tick", 32'(bus.step_tick), 32'd1);
            chk("fwd_addr", 32'(bus.addr), 32'(k % 20));
            chk("fwd_wrap", 32'(bus.wrap), 32'(k == 20));
        end
        bus.run = 1'b0;
        // reverse from zero
        pulse_rst();
        bus.run = 1'b1;
        bus.dir = 1'b1;
        repeat (4) @(negedge clk);
        chk("rev_addr19", 32'(bus.addr), 32'd19);
        chk("rev_wrap1", 32'(bus.wrap), 32'd1);
        chk("rev_tick1", 32'(bus.step_tick), 32'd1);
        repeat (4) @(negedge clk);
        chk("rev_addr18", 32'(bus.addr), 32'd18);
        chk("rev_wrap0", 32'(bus.wrap), 32'd0);
        bus.run = 1'b0;
        bus.dir = 1'b0;
        // manual steps: held level gives one step, second rising edge gives another
        bus.step_once = 1'b1;
        @(negedge clk);
        chk("man_lat1", 32'(bus.addr), 32'd18);
        @(negedge clk);
        chk("man_addr19", 32'(bus.addr), 32'd19);
        chk("man_tick", 32'(bus.step_tick), 32'd1);
        repeat (8) @(negedge clk);
        chk("man_hold_addr", 32'(bus.addr), 32'd19);
        chk("man_hold_tick", 32'(bus.step_tick), 32'd0);
        bus.step_once = 1'b0;
        repeat (2) @(negedge clk);
        bus.step_once = 1'b1;
        @(negedge clk);
        chk("man2_lat1", 32'(bus.addr), 32'd19);
        @(negedge clk);
        chk("man2_addr0", 32'(bus.addr), 32'd0);
        chk("man2_wrap", 32'(bus.wrap), 32'd1);
        chk("man2_tick", 32'(bus.step_tick), 32'd1);
        bus.step_once = 1'b0;
        @(negedge clk);
        // run=1 ignores step_once toggles
        bus.run = 1'b1;
        bus.step_once = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("tog_tick", 32'(bus.step_tick), 32'd0);
            chk("tog_addr", 32'(bus.addr), 32'd0);
            bus.step_once = (k == 1) ? 1'b0 : (k == 2) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        chk("tog_step_tick", 32'(bus.step_tick), 32'd1);
        chk("tog_step_addr", 32'(bus.addr), 32'd1);
        // freeze prescaler at 2 and resume
        repeat (2) @(negedge clk);
        bus.run = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("frz_addr", 32'(bus.addr), 32'd1);
            chk("frz_tick", 32'(bus.step_tick), 32'd0);
        end
        bus.run = 1'b1;
        @(negedge clk);
        chk("res_tick0", 32'(bus.step_tick), 32'd0);
        @(negedge clk);
        chk("res_tick1", 32'(bus.step_tick), 32'd1);
        chk("res_addr", 32'(bus.addr), 32'd2);
        // bring addr to 7 with prescaler at 3, then reset asynchronously
        pulse_rst();
        repeat (31) @(negedge clk);
        chk("pre_rst_addr", 32'(bus.addr), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_addr", 32'(bus.addr), 32'd0);
        chk("arst_com", 32'(bus.com), 32'hF);
        chk("arst_seg", 32'(bus.seg), 32'h7F);
        chk("arst_dp", 32'(bus.dp), 32'd1);
        chk("arst_tick", 32'(bus.step_tick), 32'd0);
        chk("arst_wrap", 32'(bus.wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // scan sequence from release, with stepping restarting from 0
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk("scan_com", 32'(bus.com), 32'(~(4'b0001 << (j / 3)) & 4'hF));
            chk("scan_seg", 32'(bus.seg), 32'(pat[j / 3]));
            chk("scan_dp", 32'(bus.dp), 32'((j / 3) != 2));
            if (j < 3) chk("rel_tick0", 32'(bus.step_tick), 32'd0);
            if (j == 3) begin
                chk("rel_tick1", 32'(bus.step_tick), 32'd1);
                chk("rel_addr", 32'(bus.addr), 32'd1);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
